pipo_load_arbiter: RTL and testbench
====================================

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the register data width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-003 The block SHALL have parameter HOLD, default 2, meaning the cool-down cycles after each load (0..15).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning the reset: asynchronous and active-low (0 = in reset).
REQ-006 The block SHALL have port req, input, NREQ bits, meaning per-requester load request, level-sensitive.
REQ-007 The block SHALL have port data, input, NREQ*N bits, meaning requester i's word on data[i*N +: N].
REQ-008 The block SHALL have port gnt, output, NREQ bits, meaning a one-hot, one-cycle grant/acknowledge to the requester being loaded.
REQ-009 The block SHALL have port po, output, N bits, meaning the parallel output of the internal PIPO register.
REQ-010 The block SHALL have port po_valid, output, 1 bit, meaning po holds data written since reset.
REQ-011 The block SHALL have port owner, output, clog2(NREQ) bits, meaning the index of the requester that last wrote po.
REQ-012 The block SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, LOAD and COOL; busy SHALL be 1 in LOAD and COOL.
REQ-014 In IDLE with req != 0, the arbiter SHALL select the round-robin winner in order ptr+1, ptr+2, ... modulo NREQ, latch it, and enter LOAD at the next edge.
REQ-015 In IDLE with req == 0, the FSM SHALL remain in IDLE and gnt SHALL be 0.
REQ-016 In LOAD, gnt SHALL be 1 only at bit w, where w is the latched winner, for exactly one cycle, and all other gnt bits SHALL be 0.
REQ-017 At the edge ending LOAD, the block SHALL set po to data slice w as sampled in the LOAD cycle, set po_valid to 1, set owner to w, and set ptr to w.
REQ-018 The LOAD cycle SHALL complete even if req[w] deasserts during LOAD; the requester's data is sampled regardless.
REQ-019 After LOAD, the FSM SHALL enter COOL for exactly HOLD cycles and then return to IDLE; if HOLD = 0, LOAD SHALL go directly to IDLE.
REQ-020 In COOL, req SHALL be ignored, gnt SHALL be 0, and po SHALL remain stable.
REQ-021 Latency SHALL be: req high in IDLE cycle t, gnt in cycle t+1, new po visible in cycle t+2.
REQ-022 Maximum throughput SHALL be one load per 2+HOLD cycles.
REQ-023 po, po_valid and owner SHALL change only at the edge ending LOAD, and at no other time except reset.
REQ-024 Requests that arrive in LOAD or COOL SHALL be held by the requester; they are arbitrated in the next IDLE cycle.
REQ-025 Each requester that holds req SHALL be granted within NREQ*(2+HOLD) cycles (no starvation).

Reset
REQ-026 While reset = 0, asynchronously and regardless of clk, the block SHALL force: state IDLE, ptr NREQ-1 (so requester 0 has first priority), gnt 0, po 0, po_valid 0, owner 0, busy 0.
REQ-027 If reset is asserted mid-LOAD, the block SHALL drop gnt immediately and SHALL NOT update po.
REQ-028 The first arbitration after reset release SHALL occur at the first rising edge with reset = 1.

Verification
REQ-029 Reset check: hold reset = 0 with req = 4'hF -> gnt = 0, po = 8'h00, po_valid = 0, owner = 0, busy = 0.
REQ-030 Single request: req = 4'b0010, data slice 1 = 8'hA5 in cycle t -> gnt = 4'b0010 in t+1, po = 8'hA5, po_valid = 1 and owner = 1 in t+2, busy low at t+4.
REQ-031 Fairness: req = 4'hF held, HOLD = 2 -> gnt sequence 0, 1, 2, 3, 0, with grants exactly 4 cycles apart.
REQ-032 Rotation: with ptr = 2 (last owner 2), req = 4'b1100 -> requester 3 granted; the next grant goes to requester 2.
REQ-033 Reset during LOAD: drop reset while gnt = 4'b0100 with data slice 2 = 8'h3C -> gnt = 0 in the same cycle and po stays 8'h00; after release, req = 4'hF -> requester 0 is granted first.
REQ-034 HOLD = 0 build: req = 4'b0011 held -> grants alternate 0, 1, 0, every 2 cycles, and po tracks each slice.

Source files
------------

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one requester's word into a parallel-in/parallel-out
// register, then cools down for HOLD cycles before arbitrating again.
module pipo_load_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int HOLD = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*N-1:0]         data,
    output logic [NREQ-1:0]           gnt,
    output logic [N-1:0]              po,
    output logic                      po_valid,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_COOL = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_win;
    logic [3:0]      r_cool;
    logic [N-1:0]    r_po;
    logic            r_po_valid;
    logic [IW-1:0]   r_owner;
    logic            w_found;
    logic [IW-1:0]   w_winner;

    // Search starts one past the last owner so every holder is reached within NREQ grants.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        w_found  = 1'b0;
        w_winner = r_ptr;
        idx      = 0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (!w_found && req[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        gnt          = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                gnt[r_win]   = 1'b1;
                w_next_state = (HOLD == 0) ? S_IDLE : S_COOL;
            end
            S_COOL: begin
                if (r_cool == '0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ptr resets to NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= IW'(NREQ - 1);
            r_win      <= '0;
            r_cool     <= '0;
            r_po       <= '0;
            r_po_valid <= 1'b0;
            r_owner    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win <= w_winner;
                    end
                end
                S_LOAD: begin
                    r_po       <= data[r_win*N +: N];
                    r_po_valid <= 1'b1;
                    r_owner    <= r_win;
                    r_ptr      <= r_win;
                    r_cool     <= 4'(HOLD - 1);
                end
                S_COOL: begin
                    if (r_cool != '0) begin
                        r_cool <= r_cool - 4'd1;
                    end
                end
                default: begin
                    r_cool <= '0;
                end
            endcase
        end
    end

    assign po       = r_po;
    assign po_valid = r_po_valid;
    assign owner    = r_owner;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: HOLD=2 and HOLD=0 instances share stimulus and are
// checked every cycle against a grant-schedule reference model.
module tb_pipo_load_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic            clk;
    logic            reset;
    logic [3:0]      req;
    logic [31:0]     data;
    logic [3:0]      gnt0, gnt1;
    logic [7:0]      po0, po1;
    logic            pv0, pv1;
    logic [1:0]      own0, own1;
    logic            busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each load is described by its arbitration cycle and winner.
    int         m_hold [2] = '{2, 0};
    bit         m_have [2];
    int         m_arb  [2];
    int         m_w    [2];
    int         m_last [2];
    logic [7:0] m_po   [2];
    bit         m_valid[2];
    int         m_owner[2];

    int gq[$];
    int gc[$];

    pipo_load_arbiter #(.N(N), .NREQ(NREQ), .HOLD(2)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .gnt(gnt0), .po(po0), .po_valid(pv0), .owner(own0), .busy(busy0)
    );

    pipo_load_arbiter #(.N(N), .NREQ(NREQ), .HOLD(0)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .gnt(gnt1), .po(po1), .po_valid(pv1), .owner(own1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(int last, logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh_idx(logic [3:0] g);
        for (int i = 0; i < NREQ; i++) begin
            if (g == (4'b0001 << i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_have[k]  = 1'b0;
            m_arb[k]   = 0;
            m_w[k]     = 0;
            m_last[k]  = NREQ - 1;
            m_po[k]    = 8'h00;
            m_valid[k] = 1'b0;
            m_owner[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        bit idle;
        idle = !m_have[k] || (cyc >= m_arb[k] + 2 + m_hold[k]);
        if (m_have[k] && cyc == m_arb[k] + 1) begin
            m_po[k]    = data[m_w[k]*N +: N];
            m_valid[k] = 1'b1;
            m_owner[k] = m_w[k];
            m_last[k]  = m_w[k];
        end
        if (idle && req != 4'b0000) begin
            m_w[k]    = rr_pick(m_last[k], req);
            m_arb[k]  = cyc;
            m_have[k] = 1'b1;
        end
    endtask

    task automatic compare_inst(int k, logic [3:0] g, logic [7:0] p, logic v,
                                logic [1:0] o, logic b);
        logic [3:0] exp_g;
        logic       exp_b;
        exp_g = (m_have[k] && cyc == m_arb[k] + 1) ? (4'b0001 << m_w[k]) : 4'b0000;
        exp_b = m_have[k] && (cyc > m_arb[k]) && (cyc < m_arb[k] + 2 + m_hold[k]);
        check_eq($sformatf("u%0d_gnt", k), 32'(g), 32'(exp_g));
        check_eq($sformatf("u%0d_po", k), 32'(p), 32'(m_po[k]));
        check_eq($sformatf("u%0d_po_valid", k), 32'(v), 32'(m_valid[k]));
        check_eq($sformatf("u%0d_owner", k), 32'(o), 32'(m_owner[k]));
        check_eq($sformatf("u%0d_busy", k), 32'(b), 32'(exp_b));
    endtask

    // Drive inputs for the current cycle, advance past the edge, compare.
    task automatic run_cycle(logic [3:0] r, logic [31:0] d);
        req  = r;
        data = d;
        model_step(0);
        model_step(1);
        @(negedge clk);
        cyc++;
        compare_inst(0, gnt0, po0, pv0, own0, busy0);
        compare_inst(1, gnt1, po1, pv1, own1, busy1);
    endtask

    task automatic check_reset_values(string tag);
        check_eq({tag, "_gnt0"}, 32'(gnt0), 32'h0);
        check_eq({tag, "_gnt1"}, 32'(gnt1), 32'h0);
        check_eq({tag, "_po0"}, 32'(po0), 32'h0);
        check_eq({tag, "_pv0"}, 32'(pv0), 32'h0);
        check_eq({tag, "_own0"}, 32'(own0), 32'h0);
        check_eq({tag, "_busy0"}, 32'(busy0), 32'h0);
        check_eq({tag, "_busy1"}, 32'(busy1), 32'h0);
    endtask

    // Asserts reset asynchronously mid-cycle; returns at a negedge with reset released.
    task automatic apply_reset(string tag);
        reset = 1'b0;
        #1;
        check_reset_values({tag, "_now"});
        @(posedge clk);
        @(negedge clk);
        check_reset_values({tag, "_held"});
        model_reset();
        reset = 1'b1;
    endtask

    task automatic collect(int k, int ncyc, logic [3:0] r);
        gq.delete();
        gc.delete();
        for (int i = 0; i < ncyc; i++) begin
            run_cycle(r, $urandom);
            if (k == 0 && gnt0 != 4'b0000) begin gq.push_back(oh_idx(gnt0)); gc.push_back(cyc); end
            if (k == 1 && gnt1 != 4'b0000) begin gq.push_back(oh_idx(gnt1)); gc.push_back(cyc); end
        end
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b0;
        req   = 4'hF;
        data  = $urandom;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;

        // Single request, data held across the LOAD cycle.
        d = $urandom;
        d[15:8] = 8'hA5;
        run_cycle(4'b0010, d);
        check_eq("single_gnt", 32'(gnt0), 32'h2);
        run_cycle(4'b0000, d);
        check_eq("single_po", 32'(po0), 32'hA5);
        check_eq("single_valid", 32'(pv0), 32'h1);
        check_eq("single_owner", 32'(own0), 32'h1);
        run_cycle(4'b0000, $urandom);
        run_cycle(4'b0000, $urandom);
        check_eq("single_busy_t4", 32'(busy0), 32'h0);

        // Fairness with all requesters held.
        apply_reset("rst_a");
        collect(0, 18, 4'hF);
        check_eq("fair_count", 32'(gq.size() >= 5), 32'h1);
        if (gq.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("fair_idx%0d", i), 32'(gq[i]), 32'(i % NREQ));
            end
            for (int i = 1; i < 5; i++) begin
                check_eq($sformatf("fair_gap%0d", i), 32'(gc[i] - gc[i-1]), 32'd4);
            end
        end

        // Rotation from last owner 2.
        apply_reset("rst_b");
        run_cycle(4'b0100, $urandom);
        repeat (4) run_cycle(4'b0000, $urandom);
        check_eq("rot_owner2", 32'(own0), 32'h2);
        collect(0, 10, 4'b1100);
        check_eq("rot_count", 32'(gq.size() >= 2), 32'h1);
        if (gq.size() >= 2) begin
            check_eq("rot_first", 32'(gq[0]), 32'd3);
            check_eq("rot_second", 32'(gq[1]), 32'd2);
        end

        // HOLD=0 alternation.
        apply_reset("rst_c");
        collect(1, 7, 4'b0011);
        check_eq("h0_count", 32'(gq.size() >= 3), 32'h1);
        if (gq.size() >= 3) begin
            check_eq("h0_idx0", 32'(gq[0]), 32'd0);
            check_eq("h0_idx1", 32'(gq[1]), 32'd1);
            check_eq("h0_idx2", 32'(gq[2]), 32'd0);
            check_eq("h0_gap", 32'(gc[2] - gc[0]), 32'd4);
        end

        // Reset during LOAD: no write of 3C, requester 0 first afterwards.
        apply_reset("rst_d");
        d = $urandom;
        d[23:16] = 8'h3C;
        run_cycle(4'b0100, d);
        check_eq("midload_gnt", 32'(gnt0), 32'h4);
        apply_reset("midload");
        check_eq("midload_po", 32'(po0), 32'h0);
        run_cycle(4'hF, $urandom);
        check_eq("after_rst_gnt", 32'(gnt0), 32'h1);

        // Random traffic with occasional reset during a LOAD cycle.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            run_cycle(r, $urandom);
            if (m_have[0] && cyc == m_arb[0] + 1 && $urandom_range(0, 15) == 0) begin
                apply_reset("rand_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
